pipelined_array_multiplier_pipe_reg: RTL and testbench

//  Inter-stage pipeline register placed downstream of each array-multiplier stage.
//  - Captures the stage outputs: carry, partial product and the PRODUCT_PER_STAGE final result bits.
//  - Merges the result bits into an accumulated 2*DATA_WIDTH product word.
//  - Forwards operand A and pre-shifts operand B, so the next stage can consume B[PRODUCT_PER_STAGE-1:0].
//  - 2-entry skid buffer with valid/ready handshake: full throughput, registered ready_o.

---
 rtl/pipelined_array_multiplier_pipe_reg.sv | 165 ++++++++++++++++
 tb/tb_pipelined_array_multiplier_pipe_reg.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_array_multiplier_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_array_multiplier_pipe_reg
// Purpose  : Inter-stage register for a pipelined array multiplier. It captures
//            a stage's carry, partial product and final result bits, and merges
//            the result bits into the accumulated 2*DATA_WIDTH product word. It
//            forwards operand A unchanged and operand B pre-shifted, so the next
//            stage always consumes B[PRODUCT_PER_STAGE-1:0]. Storage is a
//            2-entry skid buffer: it sustains full throughput and ready_o is
//            registered.
// Ports    : clk_i, rst_i (async, active-high)
//            upstream  : valid_i, ready_o, operand_A_i, operand_B_i,
//                        partial_product_i, carry_i, result_bits_i, product_i
//            downstream: valid_o, ready_i, operand_A_o, operand_B_o,
//                        partial_product_o, carry_o, product_o
//            flush_i   : present only when PIPELINED_MULT_FLUSH_EN is defined
// Options  : `define PIPELINED_MULT_FLUSH_EN adds a synchronous flush_i input
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_array_multiplier_pipe_reg #(
    parameter int DATA_WIDTH        = 8,
    parameter int PRODUCT_PER_STAGE = 4,
    parameter int STAGE_INDEX       = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
`ifdef PIPELINED_MULT_FLUSH_EN
    input  logic                          flush_i,
`endif
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [DATA_WIDTH-1:0]         operand_A_i,
    input  logic [DATA_WIDTH-1:0]         operand_B_i,
    input  logic [DATA_WIDTH-2:0]         partial_product_i,
    input  logic                          carry_i,
    input  logic [PRODUCT_PER_STAGE-1:0]  result_bits_i,
    input  logic [2*DATA_WIDTH-1:0]       product_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [DATA_WIDTH-1:0]         operand_A_o,
    output logic [DATA_WIDTH-1:0]         operand_B_o,
    output logic [DATA_WIDTH-2:0]         partial_product_o,
    output logic                          carry_o,
    output logic [2*DATA_WIDTH-1:0]       product_o
);

    localparam int c_PW   = 2 * DATA_WIDTH;
    localparam int c_LSB  = STAGE_INDEX * PRODUCT_PER_STAGE;
    localparam bit c_LAST = (STAGE_INDEX == (DATA_WIDTH / PRODUCT_PER_STAGE) - 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [DATA_WIDTH-2:0] pp;
        logic                  carry;
        logic [c_PW-1:0]       product;
    } beat_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t          state_q;
    beat_t           main_q;
    beat_t           skid_q;
    beat_t           beat_d;
    logic            valid_q;
    logic            ready_q;
    logic            in_fire;
    logic            out_fire;
    logic [c_PW-1:0] merged_d;

    // Product merge happens on the way in, so both M and S hold final words.
    // The last stage also owns the upper half: its carry and partial product
    // form the top DATA_WIDTH bits of the finished product.
    always_comb begin
        merged_d                           = product_i;
        merged_d[c_LSB +: PRODUCT_PER_STAGE] = result_bits_i;
        if (c_LAST) begin
            merged_d[c_PW-1:DATA_WIDTH] = {carry_i, partial_product_i};
        end
    end

    always_comb begin
        beat_d         = '0;
        beat_d.a       = operand_A_i;
        beat_d.b       = operand_B_i >> PRODUCT_PER_STAGE;
        beat_d.pp      = partial_product_i;
        beat_d.carry   = carry_i;
        beat_d.product = merged_d;
    end

    assign in_fire  = valid_i & ready_q;
    assign out_fire = valid_q & ready_i;

    // Handshake flags are registered alongside the state so ready_o never
    // depends combinationally on ready_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else
`ifdef PIPELINED_MULT_FLUSH_EN
        if (flush_i) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else
`endif
        begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_q  <= beat_d;
                        state_q <= ST_ONE;
                        valid_q <= 1'b1;
                        ready_q <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= beat_d;
                    end else if (in_fire) begin
                        // Downstream stalled: park the new beat in the skid slot.
                        skid_q  <= beat_d;
                        state_q <= ST_FULL;
                        ready_q <= 1'b0;
                    end else if (out_fire) begin
                        state_q <= ST_EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_q  <= skid_q;
                        state_q <= ST_ONE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o           = ready_q;
    assign valid_o           = valid_q;
    assign operand_A_o       = main_q.a;
    assign operand_B_o       = main_q.b;
    assign partial_product_o = main_q.pp;
    assign carry_o           = main_q.carry;
    assign product_o         = main_q.product;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_array_multiplier_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_array_multiplier_pipe_reg
// Purpose  : Self-checking bench. Two instances (stage 0 and last stage 1,
//            DW=8, PPS=4) share all inputs. A queue model of the buffer holds
//            the expected beats; directed sequences add literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_array_multiplier_pipe_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        valid_i;
    logic        ready_i;
    logic [7:0]  a_i;
    logic [7:0]  b_i;
    logic [6:0]  pp_i;
    logic        c_i;
    logic [3:0]  res_i;
    logic [15:0] prod_i;

    logic        valid_0, ready_0, c_0, valid_1, ready_1, c_1;
    logic [7:0]  a_0, b_0, a_1, b_1;
    logic [6:0]  pp_0, pp_1;
    logic [15:0] p_0, p_1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipelined_array_multiplier_pipe_reg #(
        .DATA_WIDTH(8), .PRODUCT_PER_STAGE(4), .STAGE_INDEX(0)
    ) u_s0 (
        .clk_i(clk), .rst_i(rst),
`ifdef PIPELINED_MULT_FLUSH_EN
        .flush_i(flush_i),
`endif
        .valid_i(valid_i), .ready_o(ready_0),
        .operand_A_i(a_i), .operand_B_i(b_i), .partial_product_i(pp_i),
        .carry_i(c_i), .result_bits_i(res_i), .product_i(prod_i),
        .valid_o(valid_0), .ready_i(ready_i),
        .operand_A_o(a_0), .operand_B_o(b_0), .partial_product_o(pp_0),
        .carry_o(c_0), .product_o(p_0)
    );

    pipelined_array_multiplier_pipe_reg #(
        .DATA_WIDTH(8), .PRODUCT_PER_STAGE(4), .STAGE_INDEX(1)
    ) u_s1 (
        .clk_i(clk), .rst_i(rst),
`ifdef PIPELINED_MULT_FLUSH_EN
        .flush_i(flush_i),
`endif
        .valid_i(valid_i), .ready_o(ready_1),
        .operand_A_i(a_i), .operand_B_i(b_i), .partial_product_i(pp_i),
        .carry_i(c_i), .result_bits_i(res_i), .product_i(prod_i),
        .valid_o(valid_1), .ready_i(ready_i),
        .operand_A_o(a_1), .operand_B_o(b_1), .partial_product_o(pp_1),
        .carry_o(c_1), .product_o(p_1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: a FIFO of at most two beats -------
    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [6:0]  pp;
        logic        c;
        logic [15:0] p0;
        logic [15:0] p1;
    } exp_t;

    exp_t q[$];
    exp_t e;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else if (flush_i) begin
            q.delete();
        end else begin
            // model's own handshake: ready while fewer than two beats held
            logic acc;
            acc = valid_i && (q.size() < 2);
            if (q.size() != 0 && ready_i) void'(q.pop_front());
            if (acc) begin
                e.a  = a_i;
                e.b  = b_i / 16;
                e.pp = pp_i;
                e.c  = c_i;
                e.p0 = (prod_i & 16'hFFF0) + 16'(res_i);
                e.p1 = 16'({c_i, pp_i}) * 16'd256 + 16'(res_i) * 16'd16 + (prod_i % 16'd16);
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        check("valid_o s0", 64'(valid_0), 64'(q.size() != 0));
        check("valid_o s1", 64'(valid_1), 64'(q.size() != 0));
        check("ready_o s0", 64'(ready_0), 64'(q.size() < 2));
        check("ready_o s1", 64'(ready_1), 64'(q.size() < 2));
        if (q.size() != 0) begin
            check("payload s0", 64'({a_0, b_0, pp_0, c_0, p_0}),
                  64'({q[0].a, q[0].b, q[0].pp, q[0].c, q[0].p0}));
            check("payload s1", 64'({a_1, b_1, pp_1, c_1, p_1}),
                  64'({q[0].a, q[0].b, q[0].pp, q[0].c, q[0].p1}));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [6:0] pp,
                         input logic c, input logic [3:0] r, input logic [15:0] p,
                         input logic v);
        a_i = a; b_i = b; pp_i = pp; c_i = c; res_i = r; prod_i = p; valid_i = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; ready_i = 1'b1;
        drive(8'h00, 8'h00, 7'h00, 1'b0, 4'h0, 16'h0000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset valid_o", 64'(valid_0), 64'd0);
        check("reset ready_o", 64'(ready_0), 64'd1);
        check("reset product_o", 64'(p_1), 64'd0);
        rst = 1'b0;
        step();

        // beat FF*FF stage 0
        drive(8'hFF, 8'hFF, 7'h6F, 1'b1, 4'h1, 16'h0000, 1'b1);
        step();
        check("t1 valid_o", 64'(valid_0), 64'd1);
        check("t1 B_o", 64'(b_0), 64'h0F);
        check("t1 pp_o", 64'(pp_0), 64'h6F);
        check("t1 carry_o", 64'(c_0), 64'd1);
        check("t1 product_o s0", 64'(p_0), 64'h0001);

        // last stage completes FF*FF
        drive(8'hFF, 8'h0F, 7'h7E, 1'b1, 4'h0, 16'h0001, 1'b1);
        step();
        check("t2 product_o s1", 64'(p_1), 64'hFE01);
        check("t2 product_o s0", 64'(p_0), 64'h0000);
        valid_i = 1'b0;
        step();
        check("t2 drained", 64'(valid_0), 64'd0);

        // backpressure fills the skid slot
        ready_i = 1'b0;
        drive(8'h01, 8'h00, 7'h00, 1'b0, 4'h0, 16'h0000, 1'b1);
        step();
        a_i = 8'h02;
        step();
        check("t3 ready_o full", 64'(ready_0), 64'd0);
        check("t3 A_o first", 64'(a_0), 64'h01);
        a_i = 8'h03;
        step();
        check("t3 A_o held", 64'(a_0), 64'h01);
        check("t3 ready_o held", 64'(ready_0), 64'd0);
        ready_i = 1'b1;
        step();
        check("t3 A_o second", 64'(a_0), 64'h02);
        check("t3 ready_o free", 64'(ready_0), 64'd1);
        step();
        check("t3 A_o third", 64'(a_0), 64'h03);
        valid_i = 1'b0;
        step();
        check("t3 empty", 64'(valid_0), 64'd0);

        // streaming at one beat per cycle
        for (int i = 0; i < 16; i++) begin
            drive(8'(i), 8'(i * 16), 7'(i), i[0], 4'(i), 16'(i * 257), 1'b1);
            step();
            check("t4 valid_o", 64'(valid_0), 64'd1);
            check("t4 A_o", 64'(a_0), 64'(i));
        end
        valid_i = 1'b0;
        step();
        check("t4 end valid_o", 64'(valid_0), 64'd0);

        // async reset while FULL
        ready_i = 1'b0;
        drive(8'hAA, 8'h55, 7'h33, 1'b1, 4'h9, 16'h1234, 1'b1);
        step();
        a_i = 8'hBB;
        step();
        valid_i = 1'b0;
        check("t5 full", 64'(ready_0), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check("t5 rst valid_o", 64'(valid_0), 64'd0);
        check("t5 rst ready_o", 64'(ready_0), 64'd1);
        check("t5 rst data s0", 64'({a_0, b_0, pp_0, c_0, p_0}), 64'd0);
        check("t5 rst data s1", 64'({a_1, b_1, pp_1, c_1, p_1}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready_i = 1'b1;
        step();

`ifdef PIPELINED_MULT_FLUSH_EN
        // flush while FULL, with a new beat offered in the same cycle
        ready_i = 1'b0;
        drive(8'h11, 8'h22, 7'h11, 1'b0, 4'h1, 16'h0000, 1'b1);
        step();
        a_i = 8'h12;
        step();
        check("t6 full", 64'(ready_0), 64'd0);
        flush_i = 1'b1; ready_i = 1'b1; a_i = 8'h13;
        step();
        flush_i = 1'b0; valid_i = 1'b0;
        check("t6 flush valid_o", 64'(valid_0), 64'd0);
        check("t6 flush ready_o", 64'(ready_0), 64'd1);
        step();
        check("t6 still empty", 64'(valid_0), 64'd0);
`endif

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
